// File: rtl/vga_pkg.sv
// Shared defaults and FSM encoding for the VGA framebuffer arbiter.
package vga_pkg;

    localparam int unsigned DEF_ADDR_W = 17;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_PIXELS = 76800;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        SCAN       = 1'b1
    } vga_state_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Writer handshake plus single-port RAM bus seen by the framebuffer arbiter.
interface vga_fb_arbiter_if
    import vga_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              WR_REQ;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [DATA_W-1:0] WR_DATA;
    logic              WR_ACK;
    logic              WR_ERR;

    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic              MEM_WE;
    logic [DATA_W-1:0] MEM_RDATA;

    // environment view: drives the write request and returns RAM read data
    modport master (
        output WR_REQ, WR_ADDR, WR_DATA, MEM_RDATA,
        input  WR_ACK, WR_ERR, MEM_ADDR, MEM_WDATA, MEM_WE
    );

    modport slave (
        input  WR_REQ, WR_ADDR, WR_DATA, MEM_RDATA,
        output WR_ACK, WR_ERR, MEM_ADDR, MEM_WDATA, MEM_WE
    );

endinterface

// File: rtl/vga_edge_detect.sv
// ENABLE rising-edge detector built on a registered copy of the previous ENABLE.
module vga_edge_detect (
    input  logic VGA_CLOCK,
    input  logic RESET,
    input  logic ENABLE,
    output logic en_rise
);

    logic en_prev;
    logic armed;

    // armed keeps an ENABLE held high through reset release from looking like an edge
    always_ff @(posedge VGA_CLOCK) begin
        if (RESET) begin
            en_prev <= 1'b0;
            armed   <= 1'b0;
        end else begin
            en_prev <= ENABLE;
            armed   <= armed | ~ENABLE;
        end
    end

    assign en_rise = ENABLE & ~en_prev & armed & ~RESET;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display scan-out has absolute priority, writer fills gaps.
//
// state      | meaning
// WAIT_FRAME | idle after reset, no scan-out until the first ENABLE rise
// SCAN       | display reads whenever ENABLE & H_ACTIVE
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned PIXELS = DEF_PIXELS
) (
    input  logic              VGA_CLOCK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic              H_ACTIVE,
    vga_fb_arbiter_if.slave   bus,
    output logic [DATA_W-1:0] PIX_DATA,
    output logic              PIX_VALID,
    output logic              FRAME_START
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIXELS - 1);

    vga_state_t        state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] addr_hold_q, mem_addr_d;
    logic [DATA_W-1:0] wdata_hold_q, mem_wdata_d;
    logic              mem_we_d;

    logic              en_rise;
    logic              disp_rd;
    logic              wr_grant;
    logic              wr_in_range;

    logic              wr_ack_q;
    logic              wr_err_q;
    logic              rd_pend_q;
    logic              pix_valid_q;
    logic [DATA_W-1:0] pix_data_q;
    logic              frame_start_q;

    vga_edge_detect u_edge (
        .VGA_CLOCK (VGA_CLOCK),
        .RESET     (RESET),
        .ENABLE    (ENABLE),
        .en_rise   (en_rise)
    );

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        mem_addr_d  = addr_hold_q;
        mem_wdata_d = wdata_hold_q;
        mem_we_d    = 1'b0;

        disp_rd     = ENABLE & H_ACTIVE & (state_q == SCAN) & ~RESET;
        wr_in_range = (32'(bus.WR_ADDR) < PIXELS);
        // the ACK cycle blocks a grant, so a held request is never taken twice
        wr_grant    = bus.WR_REQ & ~disp_rd & ~wr_ack_q & ~RESET;

        if (disp_rd) begin
            mem_addr_d = rd_ptr_q;
            rd_ptr_d   = (rd_ptr_q == LAST_PIX) ? '0 : rd_ptr_q + ADDR_W'(1);
        end else if (wr_grant && wr_in_range) begin
            mem_addr_d  = bus.WR_ADDR;
            mem_wdata_d = bus.WR_DATA;
            mem_we_d    = 1'b1;
        end

        if (en_rise) begin
            state_d  = SCAN;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge VGA_CLOCK) begin
        if (RESET) begin
            state_q       <= WAIT_FRAME;
            rd_ptr_q      <= '0;
            addr_hold_q   <= '0;
            wdata_hold_q  <= '0;
            wr_ack_q      <= 1'b0;
            wr_err_q      <= 1'b0;
            rd_pend_q     <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            addr_hold_q   <= mem_addr_d;
            wdata_hold_q  <= mem_wdata_d;
            wr_ack_q      <= wr_grant;
            wr_err_q      <= wr_grant & ~wr_in_range;
            rd_pend_q     <= disp_rd;
            pix_valid_q   <= rd_pend_q;
            if (rd_pend_q) begin
                pix_data_q <= bus.MEM_RDATA;
            end
            frame_start_q <= en_rise;
        end
    end

    // outputs read as reset values for the whole time RESET is high, first cycle included
    assign bus.MEM_ADDR  = RESET ? '0 : mem_addr_d;
    assign bus.MEM_WDATA = RESET ? '0 : mem_wdata_d;
    assign bus.MEM_WE    = mem_we_d & ~RESET;
    assign bus.WR_ACK    = wr_ack_q & ~RESET;
    assign bus.WR_ERR    = wr_err_q & ~RESET;
    assign PIX_VALID     = pix_valid_q & ~RESET;
    assign PIX_DATA      = RESET ? '0 : pix_data_q;
    assign FRAME_START   = frame_start_q & ~RESET;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized and directed bench for vga_fb_arbiter against a cycle-level behavioural model.
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    localparam int AW   = DEF_ADDR_W;
    localparam int DW   = DEF_DATA_W;
    localparam int NPIX = DEF_PIXELS;

    logic          VGA_CLOCK = 1'b0;
    logic          RESET;
    logic          ENABLE;
    logic          H_ACTIVE;
    logic [DW-1:0] PIX_DATA;
    logic          PIX_VALID;
    logic          FRAME_START;

    vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PIXELS(NPIX)) dut (
        .VGA_CLOCK   (VGA_CLOCK),
        .RESET       (RESET),
        .ENABLE      (ENABLE),
        .H_ACTIVE    (H_ACTIVE),
        .bus         (bus),
        .PIX_DATA    (PIX_DATA),
        .PIX_VALID   (PIX_VALID),
        .FRAME_START (FRAME_START)
    );

    always #5 VGA_CLOCK = ~VGA_CLOCK;

    // synchronous single-port RAM seen by the DUT
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge VGA_CLOCK) begin
        if (bus.MEM_WE) ram[bus.MEM_ADDR] <= bus.MEM_WDATA;
        bus.MEM_RDATA <= ram[bus.MEM_ADDR];
    end

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge VGA_CLOCK);
        #1;
    endtask

    // reference model state
    typedef struct { int due; logic [DW-1:0] data; } pix_t;
    pix_t          pend[$];
    logic [DW-1:0] shadow [NPIX];
    bit            m_scan, m_prev_low, m_ack, m_err, m_fs, m_last_known;
    int            m_ptr, m_last, cyc;
    int            we_seen, fs_seen, ack_seen, err_seen, pv_seen;

    always @(negedge VGA_CLOCK) begin : model
        bit rise, drd, grant, inr;
        cyc++;
        if (RESET) begin
            check_val("rst_mem_we",    32'(bus.MEM_WE),    0);
            check_val("rst_mem_addr",  32'(bus.MEM_ADDR),  0);
            check_val("rst_mem_wdata", 32'(bus.MEM_WDATA), 0);
            check_val("rst_wr_ack",    32'(bus.WR_ACK),    0);
            check_val("rst_wr_err",    32'(bus.WR_ERR),    0);
            check_val("rst_pix_valid", 32'(PIX_VALID),     0);
            check_val("rst_pix_data",  32'(PIX_DATA),      0);
            check_val("rst_frame_st",  32'(FRAME_START),   0);
            m_scan = 0; m_prev_low = 0; m_ack = 0; m_err = 0; m_fs = 0;
            m_ptr = 0; m_last = 0; m_last_known = 1;
            pend.delete();
        end else begin
            rise  = ENABLE && m_prev_low;
            drd   = ENABLE && H_ACTIVE && m_scan;
            grant = bus.WR_REQ && !drd && !m_ack;
            inr   = int'(bus.WR_ADDR) < NPIX;

            check_val("mem_we", 32'(bus.MEM_WE), 32'(grant && inr));
            if (drd) begin
                check_val("rd_addr", 32'(bus.MEM_ADDR), m_ptr);
            end else if (grant && inr) begin
                check_val("wr_addr", 32'(bus.MEM_ADDR), 32'(bus.WR_ADDR));
                check_val("wr_data", 32'(bus.MEM_WDATA), 32'(bus.WR_DATA));
            end else if (!grant && m_last_known) begin
                check_val("hold_addr", 32'(bus.MEM_ADDR), m_last);
            end
            check_val("wr_ack", 32'(bus.WR_ACK), 32'(m_ack));
            check_val("wr_err", 32'(bus.WR_ERR), 32'(m_err));
            check_val("frame_start", 32'(FRAME_START), 32'(m_fs));
            if (pend.size() > 0 && pend[0].due == cyc) begin
                check_val("pix_valid", 32'(PIX_VALID), 1);
                check_val("pix_data", 32'(PIX_DATA), 32'(pend[0].data));
                void'(pend.pop_front());
            end else begin
                check_val("pix_valid", 32'(PIX_VALID), 0);
            end

            if (bus.MEM_WE) we_seen++;
            if (FRAME_START) fs_seen++;
            if (bus.WR_ACK) ack_seen++;
            if (bus.WR_ERR) err_seen++;
            if (PIX_VALID) pv_seen++;

            if (drd) begin
                pend.push_back('{due: cyc + 2, data: shadow[m_ptr]});
                m_last = m_ptr; m_last_known = 1;
            end else if (grant && inr) begin
                shadow[int'(bus.WR_ADDR)] = bus.WR_DATA;
                m_last = int'(bus.WR_ADDR); m_last_known = 1;
            end else if (grant) begin
                m_last_known = 0;
            end
            m_ack = grant;
            m_err = grant && !inr;
            m_fs  = rise;
            if (rise) begin
                m_scan = 1; m_ptr = 0;
            end else if (drd) begin
                m_ptr = (m_ptr + 1) % NPIX;
            end
            m_prev_low = !ENABLE;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        int we0, fs0, ack0, err0, pv0;
        int wrap_exp [3];
        wrap_exp = '{NPIX - 1, 0, 1};
        RESET = 1; ENABLE = 0; H_ACTIVE = 0;
        bus.WR_REQ = 0; bus.WR_ADDR = '0; bus.WR_DATA = '0;
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        for (int i = 0; i < NPIX; i++) shadow[i] = '0;
        repeat (3) step();

        // first frame: four active reads from address 0
        RESET = 0; step();
        fs0 = fs_seen; pv0 = pv_seen;
        ENABLE = 1; step();
        H_ACTIVE = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge VGA_CLOCK);
            check_val("first_addr", 32'(bus.MEM_ADDR), i);
            step();
        end
        H_ACTIVE = 0;
        repeat (4) step();
        check_val("first_pv_count", pv_seen - pv0, 4);
        check_val("first_fs_count", fs_seen - fs0, 1);

        // write held off by active display, granted once blanking starts
        we0 = we_seen; ack0 = ack_seen;
        H_ACTIVE = 1; bus.WR_REQ = 1; bus.WR_ADDR = AW'(5); bus.WR_DATA = 8'hA5;
        repeat (5) step();
        check_val("held_we_count", we_seen - we0, 0);
        H_ACTIVE = 0; step();
        bus.WR_REQ = 0;
        repeat (3) step();
        check_val("held_we_count_after", we_seen - we0, 1);
        check_val("held_ack_count", ack_seen - ack0, 1);

        // out-of-range write
        we0 = we_seen; ack0 = ack_seen; err0 = err_seen;
        bus.WR_REQ = 1; bus.WR_ADDR = AW'(NPIX); bus.WR_DATA = 8'h11;
        step();
        bus.WR_REQ = 0;
        repeat (2) step();
        check_val("oor_we_count", we_seen - we0, 0);
        check_val("oor_ack_count", ack_seen - ack0, 1);
        check_val("oor_err_count", err_seen - err0, 1);

        // ENABLE high straight out of reset is not a frame start
        RESET = 1; ENABLE = 1; repeat (2) step();
        RESET = 0; H_ACTIVE = 1;
        fs0 = fs_seen; pv0 = pv_seen;
        repeat (10) step();
        check_val("noedge_pv_count", pv_seen - pv0, 0);
        check_val("noedge_fs_count", fs_seen - fs0, 0);
        ENABLE = 0; H_ACTIVE = 0; step();
        ENABLE = 1; step();
        H_ACTIVE = 1;
        @(negedge VGA_CLOCK);
        check_val("noedge_restart_addr", 32'(bus.MEM_ADDR), 0);
        repeat (4) step();
        check_val("noedge_resume_pv", 32'(pv_seen - pv0 > 0), 1);

        // reset during a granted write cycle drops the write
        H_ACTIVE = 0; step();
        we0 = we_seen; ack0 = ack_seen;
        bus.WR_REQ = 1; bus.WR_ADDR = AW'(9); bus.WR_DATA = 8'h3C; RESET = 1;
        step();
        RESET = 0; bus.WR_REQ = 0;
        repeat (3) step();
        check_val("rstwr_ack_count", ack_seen - ack0, 0);
        check_val("rstwr_we_count", we_seen - we0, 0);
        ENABLE = 0; step();
        ENABLE = 1; step();
        H_ACTIVE = 1;
        @(negedge VGA_CLOCK);
        check_val("rstwr_restart_addr", 32'(bus.MEM_ADDR), 0);
        step();

        // long scan across the pointer wrap
        ENABLE = 0; H_ACTIVE = 0; step();
        ENABLE = 1; step();
        H_ACTIVE = 1;
        for (int i = 0; i < NPIX + 2; i++) begin
            @(negedge VGA_CLOCK);
            if (i >= NPIX - 1) check_val("wrap_addr", 32'(bus.MEM_ADDR), wrap_exp[i-(NPIX-1)]);
            step();
        end
        H_ACTIVE = 0; step();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            RESET = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) ENABLE = ~ENABLE;
            H_ACTIVE = $urandom_range(0, 1) != 0;
            if (!bus.WR_REQ || bus.WR_ACK) begin
                if ($urandom_range(0, 1) != 0) begin
                    bus.WR_REQ  = 1;
                    bus.WR_ADDR = ($urandom_range(0, 9) == 0) ? AW'(NPIX + $urandom_range(0, 3))
                                                              : AW'($urandom_range(0, 31));
                    bus.WR_DATA = DW'($urandom);
                end else begin
                    bus.WR_REQ = 0;
                end
            end
            step();
        end
        RESET = 0; bus.WR_REQ = 0; H_ACTIVE = 0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
